// File: rtl/cpu7_excp_ctrl.sv
// Exception / ertn sequencer for the _e stage: prioritises causes, pulses CSR events,
// redirects the IFU and drains. Define CPU7_EXCP_INT_EN to add the interrupt source.
module cpu7_excp_ctrl #(
  parameter int GRLEN     = 32,
  parameter int DRAIN_CYC = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             ifu_exu_valid_d,
  input  logic             dec_illinst_d,
  input  logic             dec_ertn_d,
  input  logic             ecl_stall_e,
  input  logic             lsu_ale_e,
  input  logic [GRLEN-1:0] ifu_exu_pc_e,
  input  logic [GRLEN-1:0] csr_eentry,
  input  logic [GRLEN-1:0] csr_era,
  input  logic             ifu_exu_redirect_ack,
  output logic             ecl_csr_illinst_e,
  output logic             ecl_csr_ale_e,
  output logic             ecl_csr_ertn_e,
  output logic             exu_ifu_redirect_vld,
  output logic [GRLEN-1:0] exu_ifu_redirect_pc,
  output logic             ecl_flush_d,
`ifdef CPU7_EXCP_INT_EN
  input  logic             csr_int_pending,
  input  logic             csr_crmd_ie,
  output logic             ecl_csr_int_e,
`endif
  output logic             ecl_issue_block
);

  typedef enum logic [1:0] {S_IDLE, S_REDIRECT, S_DRAIN} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_valid_e, r_illinst_e, r_ertn_e;
  logic [2:0]       r_drain_cnt, w_drain_nxt;
  logic [GRLEN-1:0] r_redirect_pc;
  logic             w_idle, w_int, w_cand;
  logic             w_take_int, w_take_ill, w_take_ale, w_take_ertn, w_take;
  logic             w_cap_en;
  logic             w_unused_pc;

  // The _e pc is carried on the interface for reference only.
  assign w_unused_pc = ^ifu_exu_pc_e;

`ifdef CPU7_EXCP_INT_EN
  assign w_int         = csr_int_pending & csr_crmd_ie;
  assign ecl_csr_int_e = w_take_int;
`else
  assign w_int         = 1'b0;
`endif

  assign w_idle      = (r_state == S_IDLE);
  assign w_cand      = w_idle & r_valid_e;
  assign w_take_int  = w_cand & w_int;
  assign w_take_ill  = w_cand & ~w_int & r_illinst_e;
  assign w_take_ale  = w_cand & ~w_int & ~r_illinst_e & lsu_ale_e;
  assign w_take_ertn = w_cand & ~w_int & ~r_illinst_e & ~lsu_ale_e & r_ertn_e;
  assign w_take      = w_take_int | w_take_ill | w_take_ale | w_take_ertn;

  assign ecl_csr_illinst_e    = w_take_ill;
  assign ecl_csr_ale_e        = w_take_ale;
  assign ecl_csr_ertn_e       = w_take_ertn;
  assign exu_ifu_redirect_vld = (r_state == S_REDIRECT);
  assign exu_ifu_redirect_pc  = r_redirect_pc;
  assign ecl_flush_d          = w_take | exu_ifu_redirect_vld;
  assign ecl_issue_block      = ~w_idle;
  assign w_cap_en             = ifu_exu_valid_d & ~ecl_flush_d & ~ecl_issue_block;

  // _d->_e regs; a taken event wins over the stall so the cause cannot re-fire.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid_e   <= 1'b0;
      r_illinst_e <= 1'b0;
      r_ertn_e    <= 1'b0;
    end else if (w_take) begin
      r_valid_e   <= 1'b0;
      r_illinst_e <= 1'b0;
      r_ertn_e    <= 1'b0;
    end else if (!ecl_stall_e) begin
      r_valid_e   <= w_cap_en;
      r_illinst_e <= w_cap_en & dec_illinst_d;
      r_ertn_e    <= w_cap_en & dec_ertn_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_redirect_pc <= '0;
    end else if (w_take) begin
      r_redirect_pc <= w_take_ertn ? csr_era : csr_eentry;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_drain_cnt <= 3'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_drain_nxt = r_drain_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_take) w_state_nxt = S_REDIRECT;
      end
      S_REDIRECT: begin
        if (ifu_exu_redirect_ack) begin
          if (DRAIN_CYC == 0) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_DRAIN;
            w_drain_nxt = 3'(DRAIN_CYC);
          end
        end
      end
      S_DRAIN: begin
        if (r_drain_cnt <= 3'd1) begin
          w_state_nxt = S_IDLE;
          w_drain_nxt = 3'd0;
        end else begin
          w_drain_nxt = r_drain_cnt - 3'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_drain_nxt = 3'd0;
      end
    endcase
  end

endmodule

// File: doc/cpu7_excp_ctrl.md
Name: cpu7_excp_ctrl

Overview:
- Exception and return sequencer for the _e stage. It is the source side of the CSR exception interface.
- Collects exception causes from _d and _e, then prioritises them. Emits one-cycle ecl_csr_* event pulses to the CSR block.
- Redirects the IFU to csr_eentry (exception) or csr_era (ertn), holding the redirect until the IFU acknowledges it.
- Flushes younger instructions, then drains for a fixed number of cycles before resuming.

Parameters:
- GRLEN, 32, datapath/PC width (matches `GRLEN).
- DRAIN_CYC, 2, cycles _d->_e issue stays suppressed after redirect ack; legal range 0..7.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- ifu_exu_valid_d  in  1  valid instruction in _d
- dec_illinst_d  in  1  illegal instruction decoded in _d
- dec_ertn_d  in  1  ertn decoded in _d
- ecl_stall_e  in  1  _e stage hold; the _d->_e regs keep their value
- lsu_ale_e  in  1  misaligned access for the instruction in _e
- ifu_exu_pc_e  in  GRLEN  pc of the instruction in _e (pass-through reference only)
- csr_eentry  in  GRLEN  exception entry from CSR
- csr_era  in  GRLEN  return address from CSR
- ifu_exu_redirect_ack  in  1  IFU accepted the redirect
- ecl_csr_illinst_e  out  1  one-cycle illegal instruction event
- ecl_csr_ale_e  out  1  one-cycle alignment event
- ecl_csr_ertn_e  out  1  one-cycle ertn event
- exu_ifu_redirect_vld  out  1  redirect request
- exu_ifu_redirect_pc  out  GRLEN  redirect target
- ecl_flush_d  out  1  kill the instruction in _d
- ecl_issue_block  out  1  suppress _d->_e advance

Behaviour:
- Reset (async, resetn=0): state=IDLE; valid_e, illinst_e, ertn_e, drain counter, redirect_pc and all outputs = 0.
- _d->_e regs: valid_e, illinst_e, ertn_e capture (_d signal & ifu_exu_valid_d & ~ecl_flush_d & ~ecl_issue_block) on each edge where ~ecl_stall_e. They are cleared when an event is taken.
- Event detect, only in IDLE, valid_e=1. Priority: illinst_e > lsu_ale_e > ertn_e. Exactly one ecl_csr_* pulse per event.
- Event taken in cycle T:
  - Pulse the event output in T only.
  - Latch target at the T edge: csr_eentry for exceptions, csr_era for ertn.
  - ecl_flush_d=1 in T.
  - Go to REDIRECT at T+1.
  - Events are taken even if ecl_stall_e=1; the stall does not delay the pulse. Leaving IDLE prevents any re-fire.
- REDIRECT:
  - exu_ifu_redirect_vld=1 with a stable exu_ifu_redirect_pc.
  - ecl_flush_d=1, ecl_issue_block=1.
  - Stay until ifu_exu_redirect_ack=1. On the ack edge, load counter=DRAIN_CYC and go to DRAIN, or to IDLE if DRAIN_CYC=0.
  - Ack in the same cycle redirect first asserts: accepted, a 1-cycle REDIRECT.
- DRAIN:
  - ecl_issue_block=1; redirect_vld=0.
  - Decrement each cycle; go to IDLE when the counter reaches 1. Total DRAIN_CYC cycles.
  - _e events are ignored; the regs were cleared.
- Simultaneous cases:
  - illinst_e+ale: only illinst fires.
  - ale+ertn: only ale fires, with target eentry.
  - New _d ertn/illinst while not IDLE: flushed, never captured.
- Reset during REDIRECT/DRAIN: immediate return to IDLE, redirect dropped, no pulse.
- Redirect timing: csr_era is sampled in the ertn cycle, before any CSR write is committed by this block. csr_eentry is sampled in the exception cycle.

Optional Feature:
- Macro: CPU7_EXCP_INT_EN.
- When defined, adds inputs csr_int_pending (1) and csr_crmd_ie (1), and output ecl_csr_int_e (1).
  - In IDLE with valid_e=1, csr_int_pending&csr_crmd_ie has the highest priority, above illinst.
  - It pulses ecl_csr_int_e and redirects to csr_eentry; the instruction in _e is killed.
- When undefined, those ports and that logic are absent and the priority order is unchanged.

Test Plan:
- illinst at _d (pc 0x1c000010), eentry=0x1c008000:
  - ecl_csr_illinst_e pulses 1 cycle later for exactly 1 cycle.
  - redirect_vld=1 with pc 0x1c008000 until ack.
  - issue_block holds for 2 cycles after ack, then IDLE.
- lsu_ale_e=1 with illinst_e=1 in the same cycle -> only illinst pulse; ale never pulses, even if held high for 3 cycles.
- ertn in _d, era=0x1c000104, ack delayed 4 cycles:
  - ecl_csr_ertn_e pulses once.
  - redirect_pc=0x1c000104 stable all 5 REDIRECT cycles.
  - illinst in _d during REDIRECT is flushed, with no pulse.
- ack in the first redirect cycle with DRAIN_CYC=0 -> redirect_vld high 1 cycle, back in IDLE the next cycle, next instruction issues.
- resetn low mid-REDIRECT -> redirect_vld, issue_block and flush drop asynchronously. After release, state is IDLE and a new ale event is handled normally.
- With CPU7_EXCP_INT_EN defined, int_pending=1, crmd_ie=1 together with ale_e=1 -> only ecl_csr_int_e pulses, redirect to eentry. With crmd_ie=0 -> ale is taken.
